// File: rtl/crc32_stream_engine.sv
// CRC32 (IEEE 802.3) over an AXI-stream: one-stage forwarding slice plus a
// per-frame result FIFO carrying CRC, kept-byte length and FCS-residue flag.

module crc32_byte_step (
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  input  logic        en,
  output logic [31:0] crc_out
);
  logic [31:0] c;
  always_comb begin
    c = crc_in ^ {24'd0, byte_in};
    for (int b = 0; b < 8; b++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    crc_out = en ? c : crc_in;
  end
endmodule

module crc32_stream_engine #(
  parameter int DATA_WIDTH    = 256,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int CRC_WIDTH     = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int RES_DEPTH     = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_data_stream_tvalid,
  output logic                     s_data_stream_tready,
  input  logic                     s_data_stream_tlast,
  input  logic [DATA_WIDTH-1:0]    s_data_stream_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_data_stream_tkeep,
  output logic                     m_data_stream_tvalid,
  input  logic                     m_data_stream_tready,
  output logic                     m_data_stream_tlast,
  output logic [DATA_WIDTH-1:0]    m_data_stream_tdata,
  output logic [KEEP_WIDTH-1:0]    m_data_stream_tkeep,
  output logic                     m_crc_stream_valid,
  input  logic                     m_crc_stream_ready,
  output logic [CRC_WIDTH-1:0]     m_crc_stream_data,
  output logic [LEN_WIDTH-1:0]     m_crc_stream_len,
  output logic                     m_crc_stream_ok,
  output logic [ERR_CNT_WIDTH-1:0] fcs_err_count
);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = $clog2(KEEP_WIDTH+1);
  localparam logic [CRC_WIDTH-1:0] RESIDUE = 32'h2144DF1C;

  typedef struct packed {
    logic [CRC_WIDTH-1:0] crc;
    logic [LEN_WIDTH-1:0] len;
    logic                 ok;
  } res_t;

  logic [CRC_WIDTH-1:0] crc_q;
  logic [LEN_WIDTH-1:0] len_q, len_next;
  logic [KEEP_WIDTH:0][CRC_WIDTH-1:0] crc_chain;
  logic [CNT_W-1:0]     keep_cnt;
  logic [LEN_WIDTH:0]   len_sum;
  logic                 accept, push, pop, res_full, res_empty;
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  res_t                 mem [RES_DEPTH];
  res_t                 push_entry, rd_entry;

  assign accept = s_data_stream_tvalid & s_data_stream_tready;
  assign push   = accept & s_data_stream_tlast;
  assign pop    = m_crc_stream_valid & m_crc_stream_ready;

  // Blocking on a full FIFO even for non-last beats keeps push-when-full impossible.
  assign s_data_stream_tready = reset_n & (!m_data_stream_tvalid | m_data_stream_tready) & !res_full;

  // Byte lanes chained in wire order; a cleared keep bit passes the CRC through.
  assign crc_chain[0] = crc_q;
  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    crc32_byte_step u_step (
      .crc_in  (crc_chain[i]),
      .byte_in (s_data_stream_tdata[8*i +: 8]),
      .en      (s_data_stream_tkeep[i]),
      .crc_out (crc_chain[i+1])
    );
  end

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) keep_cnt += CNT_W'(s_data_stream_tkeep[i]);
  end

  assign len_sum  = {1'b0, len_q} + (LEN_WIDTH+1)'(keep_cnt);
  assign len_next = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

  assign push_entry.crc = crc_chain[KEEP_WIDTH] ^ '1;
  assign push_entry.len = len_next;
  assign push_entry.ok  = (push_entry.crc == RESIDUE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_data_stream_tvalid <= 1'b0;
      m_data_stream_tlast  <= 1'b0;
      m_data_stream_tdata  <= '0;
      m_data_stream_tkeep  <= '0;
    end else if (accept) begin
      m_data_stream_tvalid <= 1'b1;
      m_data_stream_tlast  <= s_data_stream_tlast;
      m_data_stream_tdata  <= s_data_stream_tdata;
      m_data_stream_tkeep  <= s_data_stream_tkeep;
    end else if (m_data_stream_tready) begin
      m_data_stream_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '1;
      len_q <= '0;
    end else if (accept) begin
      crc_q <= s_data_stream_tlast ? '1 : crc_chain[KEEP_WIDTH];
      len_q <= s_data_stream_tlast ? '0 : len_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fcs_err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_entry.ok && fcs_err_count != '1)
        fcs_err_count <= fcs_err_count + 1'b1;
    end
  end

  assign res_empty = (wr_ptr == rd_ptr);
  assign res_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign rd_entry  = res_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

  assign m_crc_stream_valid = !res_empty;
  assign m_crc_stream_data  = rd_entry.crc;
  assign m_crc_stream_len   = rd_entry.len;
  assign m_crc_stream_ok    = rd_entry.ok;
endmodule

// File: tb/tb_crc32_stream_engine.sv
// Randomized bench for crc32_stream_engine: byte-queue model with a table CRC,
// scoreboarded data beats and results, plus directed literal expectations.

module tb_crc32_stream_engine;
  localparam int DW = 256, KW = 32, LW = 16, EW = 16;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          m_tvalid, m_tready = 1'b0, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          crc_valid, crc_ready = 1'b0, crc_ok;
  logic [31:0]   crc_data;
  logic [LW-1:0] crc_len;
  logic [EW-1:0] fcs_cnt;

  always #5 clk = ~clk;

  crc32_stream_engine #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CRC_WIDTH(32), .LEN_WIDTH(LW),
                        .RES_DEPTH(4), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_data_stream_tvalid(s_tvalid), .s_data_stream_tready(s_tready),
    .s_data_stream_tlast(s_tlast), .s_data_stream_tdata(s_tdata), .s_data_stream_tkeep(s_tkeep),
    .m_data_stream_tvalid(m_tvalid), .m_data_stream_tready(m_tready),
    .m_data_stream_tlast(m_tlast), .m_data_stream_tdata(m_tdata), .m_data_stream_tkeep(m_tkeep),
    .m_crc_stream_valid(crc_valid), .m_crc_stream_ready(crc_ready),
    .m_crc_stream_data(crc_data), .m_crc_stream_len(crc_len), .m_crc_stream_ok(crc_ok),
    .fcs_err_count(fcs_cnt)
  );

  typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } beat_t;
  typedef struct { logic [31:0] c; logic [LW-1:0] n; logic ok; } res_t;

  beat_t         exp_beats[$];
  res_t          exp_res[$];
  logic [7:0]    frame_q[$];
  logic [EW-1:0] exp_err = '0;
  int            checks = 0, errors = 0, n_popped = 0;
  logic [31:0]   last_crc = '0;
  logic [LW-1:0] last_len = '0;
  logic          last_ok = 1'b0;
  logic          rand_bp = 1'b0, m_tready_fix = 1'b0, crc_ready_fix = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [7:0] q[$]);
    logic [31:0] tbl [256];
    logic [31:0] c;
    logic [7:0]  idx;
    for (int n = 0; n < 256; n++) begin
      c = 32'(n);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      tbl[n] = c;
    end
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      idx = c[7:0] ^ q[i];
      c = tbl[idx] ^ (c >> 8);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  // Ready drivers: random when rand_bp, otherwise the fixed values.
  initial forever begin
    @(posedge clk); #2;
    m_tready  = rand_bp ? 1'($urandom_range(0, 1)) : m_tready_fix;
    crc_ready = rand_bp ? 1'($urandom_range(0, 1)) : crc_ready_fix;
  end

  // Model update on every accepted input beat.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      exp_beats.delete(); exp_res.delete(); frame_q.delete(); exp_err = '0;
    end else if (s_tvalid && s_tready) begin
      beat_t b;
      res_t  r;
      b.d = s_tdata; b.k = s_tkeep; b.l = s_tlast;
      exp_beats.push_back(b);
      for (int i = 0; i < KW; i++) if (s_tkeep[i]) frame_q.push_back(s_tdata[8*i +: 8]);
      if (s_tlast) begin
        r.c  = crc_model(frame_q);
        r.n  = (frame_q.size() > 65535) ? 16'hFFFF : LW'(frame_q.size());
        r.ok = (r.c == 32'h2144DF1C);
        exp_res.push_back(r);
        if (!r.ok && exp_err != '1) exp_err = exp_err + 1'b1;
        frame_q.delete();
      end
    end
  end

  // Compare process: every cycle out of reset.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("tvalid_occupancy", 256'(m_tvalid), 256'(exp_beats.size() != 0));
      chk("crc_valid_occupancy", 256'(crc_valid), 256'(exp_res.size() != 0));
      chk("fcs_err_count", 256'(fcs_cnt), 256'(exp_err));
      if (m_tvalid && m_tready && exp_beats.size() != 0) begin
        beat_t b;
        b = exp_beats.pop_front();
        chk("beat_tdata", m_tdata, b.d);
        chk("beat_tkeep", 256'(m_tkeep), 256'(b.k));
        chk("beat_tlast", 256'(m_tlast), 256'(b.l));
      end
      if (crc_valid && crc_ready && exp_res.size() != 0) begin
        res_t r;
        r = exp_res.pop_front();
        chk("res_crc", 256'(crc_data), 256'(r.c));
        chk("res_len", 256'(crc_len), 256'(r.n));
        chk("res_ok", 256'(crc_ok), 256'(r.ok));
        last_crc = crc_data; last_len = crc_len; last_ok = crc_ok;
        n_popped++;
      end
    end
  end

  function automatic void pack(input logic [7:0] q[$], output logic [DW-1:0] d, output logic [KW-1:0] k);
    d = {8{$urandom}};
    k = '0;
    foreach (q[i]) begin d[8*i +: 8] = q[i]; k[i] = 1'b1; end
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!s_tready && n < 1000);
    if (!s_tready) chk("send_timeout", 256'(0), 256'(1));
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    pack(q, d, k);
    send_beat(d, k, 1'b1);
  endtask

  task automatic send_rand_frame(input int nb);
    for (int i = 0; i < nb; i++) begin
      logic [KW-1:0] k;
      case ($urandom_range(0, 3))
        0: k = '1;
        1: k = '0;
        default: k = $urandom;
      endcase
      send_beat({8{$urandom}}, k, i == nb - 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_beats.size() != 0 || exp_res.size() != 0) && n < 3000) begin
      @(posedge clk); n++;
    end
    chk("drain", 256'(exp_beats.size() + exp_res.size()), 256'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    q9[$], q13[$], qz[$], q4[$], q5[$], qf[$];
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    int            p0, n;

    for (int i = 0; i < 9; i++) q9.push_back(8'(8'h31 + i));
    q13 = q9; q13.push_back(8'h26); q13.push_back(8'h39); q13.push_back(8'hF4); q13.push_back(8'hCB);
    for (int i = 0; i < 32; i++) qz.push_back(8'h00);
    for (int i = 0; i < 4; i++) q4.push_back(q9[i]);
    for (int i = 4; i < 9; i++) q5.push_back(q9[i]);

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 256'(s_tready), 256'(0));
    chk("rst_m_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_m_tdata", m_tdata, 256'(0));
    chk("rst_crc_valid", 256'(crc_valid), 256'(0));
    chk("rst_crc_data", 256'(crc_data), 256'(0));
    chk("rst_crc_len", 256'(crc_len), 256'(0));
    chk("rst_fcs", 256'(fcs_cnt), 256'(0));
    @(posedge clk); #1;
    reset_n = 1'b1; m_tready_fix = 1'b1; crc_ready_fix = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Pin the model against known CRCs.
    chk("model_check", 256'(crc_model(q9)), 256'(32'hCBF43926));
    chk("model_residue", 256'(crc_model(q13)), 256'(32'h2144DF1C));
    chk("model_zero32", 256'(crc_model(qz)), 256'(32'h190A55AD));

    p0 = n_popped;
    send_bytes(q9); wait_drain();
    chk("t1_pops", 256'(n_popped - p0), 256'(1));
    chk("t1_crc", 256'(last_crc), 256'(32'hCBF43926));
    chk("t1_len", 256'(last_len), 256'(9));
    chk("t1_ok", 256'(last_ok), 256'(0));
    chk("t1_fcs", 256'(fcs_cnt), 256'(1));

    send_bytes(q13); wait_drain();
    chk("t2_crc", 256'(last_crc), 256'(32'h2144DF1C));
    chk("t2_len", 256'(last_len), 256'(13));
    chk("t2_ok", 256'(last_ok), 256'(1));
    chk("t2_fcs", 256'(fcs_cnt), 256'(1));

    pack(q4, d, k); send_beat(d, k, 1'b0);
    pack(q5, d, k); send_beat(d, k, 1'b1);
    wait_drain();
    chk("t3_crc", 256'(last_crc), 256'(32'hCBF43926));
    chk("t3_len", 256'(last_len), 256'(9));

    send_bytes(qz); wait_drain();
    chk("t4_crc", 256'(last_crc), 256'(32'h190A55AD));
    chk("t4_len", 256'(last_len), 256'(32));

    // Result FIFO fill: four frames land, the fifth waits for one pop.
    crc_ready_fix = 1'b0;
    @(posedge clk); #1;
    p0 = n_popped;
    for (int f = 0; f < 4; f++) begin
      qf.delete();
      for (int i = 0; i < 1 + f * 3; i++) qf.push_back(8'($urandom));
      send_bytes(qf);
    end
    qf.delete();
    for (int i = 0; i < 7; i++) qf.push_back(8'($urandom));
    pack(qf, d, k);
    s_tdata = d; s_tkeep = k; s_tlast = 1'b1; s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_tready_low", 256'(s_tready), 256'(0));
    end
    chk("full_no_pops", 256'(n_popped - p0), 256'(0));
    @(posedge clk); #1 crc_ready_fix = 1'b1;
    @(posedge clk); #1 crc_ready_fix = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_tready && n < 100);
    chk("full_fifth_accepted", 256'(s_tready), 256'(1));
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("full_one_pop", 256'(n_popped - p0), 256'(1));
    crc_ready_fix = 1'b1;
    wait_drain();
    chk("full_total_pops", 256'(n_popped - p0), 256'(5));
    chk("full_last_is_fifth", 256'(last_crc), 256'(crc_model(qf)));

    // Random backpressure on both outputs.
    rand_bp = 1'b1;
    send_rand_frame(10);
    for (int f = 0; f < 30; f++) send_rand_frame($urandom_range(1, 3));
    wait_drain();
    rand_bp = 1'b0;
    @(posedge clk); #1;

    // Reset mid-frame: the interrupted frame yields nothing.
    send_beat({8{$urandom}}, '1, 1'b0);
    send_beat({8{$urandom}}, '1, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_m_tvalid", 256'(m_tvalid), 256'(0));
    chk("rst_mid_crc_valid", 256'(crc_valid), 256'(0));
    chk("rst_mid_s_tready", 256'(s_tready), 256'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    p0 = n_popped;
    send_bytes(q9); wait_drain();
    chk("rst_mid_pops", 256'(n_popped - p0), 256'(1));
    chk("rst_mid_crc", 256'(last_crc), 256'(32'hCBF43926));
    chk("rst_mid_fcs", 256'(fcs_cnt), 256'(1));

    send_beat({8{$urandom}}, '0, 1'b1);
    wait_drain();
    chk("empty_crc", 256'(last_crc), 256'(0));
    chk("empty_len", 256'(last_len), 256'(0));
    chk("empty_ok", 256'(last_ok), 256'(0));
    chk("empty_fcs", 256'(fcs_cnt), 256'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
